conv_line_ctrl: RTL and testbench

Line-buffer controller and read scheduler that feeds the 3x3 convolution datapath. It accepts one 8-bit pixel per cycle in raster order and stores rows round-robin into four line buffers. When three complete rows are buffered, it streams 72-bit 3x3 windows to the convolver, one per cycle. When a row has been consumed, it pulses an interrupt so the host DMA can supply the next row.

---
 rtl/conv_line_ctrl_pkg.sv | 19 +
 rtl/conv_line_buffer.sv | 46 ++++
 rtl/conv_line_ctrl.sv | 129 ++++++++++++
 tb/tb_conv_line_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_line_ctrl_pkg.sv
// Shared types, geometry constants and window packing for the 3x3 line-buffer controller.
package conv_line_ctrl_pkg;

  localparam int NUM_LINES  = 4;
  localparam int KERNEL_DIM = 3;
  localparam int PIX_W      = 8;
  localparam int WIN_W      = KERNEL_DIM * KERNEL_DIM * PIX_W;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  // Bit offset of window row r (0 = oldest line) and column c.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return PIX_W * (KERNEL_DIM * r + c);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of storage: synchronous write port, registered three-tap read
// at ptr, ptr+1, ptr+2 with zeros past the right edge.
module conv_line_buffer
  import conv_line_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  localparam int AW = $clog2(IMG_WIDTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,
  input  logic [AW-1:0]               wr_addr_i,
  input  logic [PIX_W-1:0]            wr_data_i,
  input  logic                        rd_en_i,
  input  logic [AW-1:0]               rd_ptr_i,
  output logic [KERNEL_DIM*PIX_W-1:0] taps_o
);

  localparam logic [AW+1:0] W_L = (AW+2)'(IMG_WIDTH);

  logic [PIX_W-1:0]            mem_q [IMG_WIDTH];
  logic [KERNEL_DIM*PIX_W-1:0] taps_q, taps_d;
  logic [AW+1:0]               col [KERNEL_DIM];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Taps hold between reads so the window output stays stable while idle.
  always_comb begin
    taps_d = taps_q;
    for (int c = 0; c < KERNEL_DIM; c++) begin
      col[c] = {2'b00, rd_ptr_i} + (AW+2)'(c);
      if (rd_en_i)
        taps_d[c*PIX_W +: PIX_W] = (col[c] < W_L) ? mem_q[col[c][AW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) taps_q <= '0;
    else         taps_q <= taps_d;
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/conv_line_ctrl.sv
// Line-buffer controller: round-robin row storage in four lines, and a read
// scheduler that streams 3x3 windows once three full rows are buffered.
module conv_line_ctrl
  import conv_line_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH = 512
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_intr,
  output logic             o_overflow
);

  localparam int CNT_W = $clog2(4*IMG_WIDTH+1);
  localparam int AW    = $clog2(IMG_WIDTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(NUM_LINES * IMG_WIDTH);
  localparam logic [CNT_W-1:0] START = CNT_W'(KERNEL_DIM * IMG_WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_q, fill_d;
  logic [1:0]                  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, win_sel_q, win_sel_d;
  logic                        vld_q, intr_q, ovf_q, ovf_d;
  logic                        wr_acc, rd_en, rd_last;
  logic [KERNEL_DIM*PIX_W-1:0] taps [NUM_LINES];

  assign wr_acc  = i_pixel_data_valid && (fill_q != FULL);
  assign rd_en   = (state_q == READ);
  assign rd_last = rd_en && (rd_ptr_q == LAST);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    wr_sel_d  = wr_sel_q;
    rd_ptr_d  = rd_ptr_q;
    rd_sel_d  = rd_sel_q;
    win_sel_d = win_sel_q;
    fill_d    = fill_q;
    ovf_d     = ovf_q;

    if (wr_acc) begin
      if (wr_ptr_q == LAST) begin
        wr_ptr_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_ptr_d = wr_ptr_q + ONE;
      end
    end
    if (i_pixel_data_valid && !wr_acc) ovf_d = 1'b1;

    case ({wr_acc, rd_en})
      2'b10:   fill_d = fill_q + ONE;
      2'b01:   fill_d = fill_q - ONE;
      default: fill_d = fill_q;
    endcase

    // win_sel remembers which line was oldest for the window now in the tap registers.
    case (state_q)
      IDLE: if (fill_q >= START) state_d = READ;
      READ: begin
        win_sel_d = rd_sel_q;
        if (rd_last) begin
          rd_ptr_d = '0;
          rd_sel_d = rd_sel_q + 2'd1;
          state_d  = IDLE;
        end else begin
          rd_ptr_d = rd_ptr_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      wr_sel_q  <= '0;
      rd_ptr_q  <= '0;
      rd_sel_q  <= '0;
      win_sel_q <= '0;
      fill_q    <= '0;
      vld_q     <= 1'b0;
      intr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_sel_q  <= wr_sel_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_sel_q  <= rd_sel_d;
      win_sel_q <= win_sel_d;
      fill_q    <= fill_d;
      vld_q     <= rd_en;
      intr_q    <= rd_last;
      ovf_q     <= ovf_d;
    end
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    conv_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_buf (
      .clk_i     (i_clk),
      .rst_ni    (i_rst_n),
      .wr_en_i   (wr_acc && (wr_sel_q == 2'(i))),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (i_pixel_data),
      .rd_en_i   (rd_en),
      .rd_ptr_i  (rd_ptr_q[AW-1:0]),
      .taps_o    (taps[i])
    );
  end

  always_comb begin
    o_pixel_data = '0;
    for (int r = 0; r < KERNEL_DIM; r++)
      for (int c = 0; c < KERNEL_DIM; c++)
        o_pixel_data[win_idx(r, c) +: PIX_W] = taps[2'(win_sel_q + 2'(r))][c*PIX_W +: PIX_W];
  end

  assign o_pixel_data_valid = vld_q;
  assign o_intr             = intr_q;
  assign o_overflow         = ovf_q;

endmodule

// File: tb/tb_conv_line_ctrl.sv
// Scoreboard bench for conv_line_ctrl at IMG_WIDTH=8: expected windows are built
// from the pixels driven and compared as the DUT streams them out.
`timescale 1ns/1ps
module tb_conv_line_ctrl;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pix;
  logic        pix_vld;
  logic [71:0] win;
  logic        win_vld, intr, ovf;

  always #5 clk = ~clk;

  conv_line_ctrl #(.IMG_WIDTH(W)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_pixel_data       (pix),
    .i_pixel_data_valid (pix_vld),
    .o_pixel_data       (win),
    .o_pixel_data_valid (win_vld),
    .o_intr             (intr),
    .o_overflow         (ovf)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [71:0] exp_q [$];
  bit          sb_en;
  logic [7:0]  img [6][W];
  int          row, col, last_wr, wr_edge, bv, bi;

  int          vld_cnt = 0;
  int          intr_cnt = 0;
  int          ovf_cyc = -1;
  bit          ovf_prev = 1'b0;
  int          vld_cyc [$];
  int          intr_cyc [$];
  logic [71:0] win_log [$];
  logic [71:0] last_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (win_vld) begin
      vld_cnt++;
      vld_cyc.push_back(cyc);
      win_log.push_back(win);
      if (sb_en) begin
        if (exp_q.size() == 0) chk("sb_underflow", 72'(win_vld), 72'(0));
        else begin
          last_exp = exp_q.pop_front();
          chk("window", win, last_exp);
        end
      end
    end
    if (intr) begin
      intr_cnt++;
      intr_cyc.push_back(cyc);
      chk("intr_with_vld", 72'(win_vld), 72'(1));
    end
    if (ovf && !ovf_prev) ovf_cyc = cyc;
    ovf_prev = ovf;
  end

  function automatic int vld_at(input int i);
    return (vld_cyc.size() > bv + i) ? vld_cyc[bv + i] : -1000;
  endfunction

  function automatic int intr_at(input int i);
    return (intr_cyc.size() > bi + i) ? intr_cyc[bi + i] : -1000;
  endfunction

  function automatic logic [71:0] win_at(input int i);
    return (win_log.size() > bv + i) ? win_log[bv + i] : 'x;
  endfunction

  task automatic push_windows(input int top);
    logic [71:0] w;
    for (int p = 0; p < W; p++) begin
      w = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          if (p + c < W) w[8*(3*r+c) +: 8] = img[top+r][p+c];
      exp_q.push_back(w);
    end
  endtask

  task automatic put_pix(input logic [7:0] d);
    @(negedge clk);
    pix_vld = 1'b1;
    pix     = d;
    last_wr = cyc + 1;
    if (row < 6) img[row][col] = d;
    if (col == W - 1) begin
      col = 0;
      row++;
      if (sb_en && row >= 3 && row <= 6) push_windows(row - 3);
    end else begin
      col++;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_vld = 1'b0;
    end
  endtask

  task automatic wait_out(input string tag, input int n_vld, input int n_intr, input int budget);
    int k = 0;
    while ((vld_cnt - bv < n_vld || intr_cnt - bi < n_intr) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_in_time"}, 72'(k < budget), 72'(1));
  endtask

  task automatic rst_assert();
    #2;
    rst_n   = 1'b0;
    pix_vld = 1'b0;
    #1;
    chk("rst_win", win, '0);
    chk("rst_vld", 72'(win_vld), 72'(0));
    chk("rst_intr", 72'(intr), 72'(0));
    chk("rst_ovf", 72'(ovf), 72'(0));
    exp_q.delete();
    row = 0;
    col = 0;
    bv  = vld_cnt;
    bi  = intr_cnt;
  endtask

  task automatic rst_release();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pix = '0; pix_vld = 1'b0; sb_en = 1'b1;
    row = 0; col = 0; bv = 0; bi = 0;
    repeat (3) @(negedge clk);
    rst_assert();
    rst_release();

    // Three rows, no gaps: latency, first/last windows, padding, one interrupt.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) put_pix(8'(16*r + c));
    wr_edge = last_wr;
    gap(1);
    wait_out("t1", 8, 1, 40);
    gap(4);
    chk("t1_latency", 72'(vld_at(0) - wr_edge), 72'(2));
    chk("t1_vld_cnt", 72'(vld_cnt - bv), 72'(8));
    chk("t1_intr_cnt", 72'(intr_cnt - bi), 72'(1));
    chk("t1_intr_at_last", 72'(intr_at(0) - vld_at(7)), 72'(0));
    chk("t1_win0", win_at(0), 72'h22_21_20_12_11_10_02_01_00);
    chk("t1_win6_pad", win_at(6), 72'h00_27_26_00_17_16_00_07_06);
    chk("t1_win7_pad", win_at(7), 72'h00_00_27_00_00_17_00_00_07);
    chk("t1_hold_data", win, 72'h00_00_27_00_00_17_00_00_07);
    chk("t1_hold_vld", 72'(win_vld), 72'(0));
    chk("t1_sb_left", 72'(exp_q.size()), 72'(0));

    // Six rows streamed back to back: four bursts, select wrap, 9-cycle cadence.
    @(negedge clk);
    rst_assert();
    rst_release();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < W; c++) put_pix(8'(r*37 + c*11 + 5));
    gap(1);
    wait_out("t2", 32, 4, 120);
    gap(4);
    chk("t2_vld_cnt", 72'(vld_cnt - bv), 72'(32));
    chk("t2_intr_cnt", 72'(intr_cnt - bi), 72'(4));
    for (int i = 1; i < 4; i++)
      chk("t2_intr_gap", 72'(intr_at(i) - intr_at(i-1)), 72'(9));
    chk("t2_sb_left", 72'(exp_q.size()), 72'(0));

    // Write and read together while exactly three rows are buffered.
    @(negedge clk);
    rst_assert();
    rst_release();
    for (int i = 0; i < 32; i++) begin
      if (i == 24) gap(1);
      put_pix(8'(i*50 + 1));
    end
    gap(1);
    wait_out("t3", 16, 2, 80);
    gap(4);
    chk("t3_vld_cnt", 72'(vld_cnt - bv), 72'(16));
    chk("t3_intr_cnt", 72'(intr_cnt - bi), 72'(2));
    chk("t3_intr_gap", 72'(intr_at(1) - intr_at(0)), 72'(9));
    chk("t3_sb_left", 72'(exp_q.size()), 72'(0));

    // Writes outpace reads by one pixel per row; the 89th write meets a full buffer.
    @(negedge clk);
    rst_assert();
    rst_release();
    sb_en = 1'b0;
    put_pix(8'd1);
    wr_edge = last_wr;
    for (int k = 2; k <= 100; k++) put_pix(8'(k));
    gap(1);
    chk("t4_ovf_write_idx", 72'(ovf_cyc - wr_edge + 1), 72'(89));
    gap(30);
    chk("t4_ovf_sticky", 72'(ovf), 72'(1));
    @(negedge clk);
    rst_assert();
    rst_release();
    sb_en = 1'b1;

    // Reset in the middle of a read burst, then a fresh fill.
    for (int i = 0; i < 24; i++) put_pix(8'(i*16 + 128));
    wr_edge = last_wr;
    gap(1);
    while (cyc < wr_edge + 5) @(negedge clk);
    chk("t5_pre_vld", 72'(win_vld), 72'(1));
    rst_assert();
    rst_release();
    for (int i = 0; i < 24; i++) begin
      if (i == 23) begin
        gap(10);
        chk("t5_no_vld", 72'(vld_cnt - bv), 72'(0));
        chk("t5_no_intr", 72'(intr_cnt - bi), 72'(0));
      end
      put_pix(8'(i*7 + 3));
    end
    wr_edge = last_wr;
    gap(1);
    wait_out("t5", 8, 1, 40);
    gap(4);
    chk("t5_latency", 72'(vld_at(0) - wr_edge), 72'(2));
    chk("t5_vld_cnt", 72'(vld_cnt - bv), 72'(8));
    chk("t5_intr_cnt", 72'(intr_cnt - bi), 72'(1));
    chk("t5_sb_left", 72'(exp_q.size()), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
